fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the riscfw core.
- Consumes the branch unit's redirect (jal/jalr link, or taken conditional branch) and steers the fetch PC.
- Issues word reads to instruction memory over a valid/ready request channel and presents fetched instructions to decode through a 1-entry valid/ready output register.
- Discards stale responses after a redirect and reports misaligned-target and access faults in-band.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (must be 4-byte aligned).

Ports:
clk  in  1  core clock; all state changes on rising edge.
rst_n  in  1  asynchronous, active-low reset.
redirect_valid  in  1  single-cycle pulse from BU path: (link | taken) & ~error.
redirect_target  in  32  new PC (BU target).
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  32  word address of request (equals fetch_pc).
imem_resp_valid  in  1  response valid (exactly one per accepted request, ≥1 cycle after acceptance).
imem_resp_data  in  32  instruction word.
imem_resp_err  in  1  access fault on this response.
if_valid  out  1  output register holds an entry.
if_ready  in  1  decode accepts entry.
if_pc  out  32  PC of the entry.
if_instr  out  32  instruction; 0 on fault entries.
if_fault  out  2  0 = none, 1 = misaligned target, 2 = access fault.

Behaviour:
Reset (async assert, sync-free release):
- if_valid = 0, imem_req_valid = 0, if_pc/if_instr/if_fault = 0.
- fetch_pc = RESET_PC, state = REQ.

Registers:
- fetch_pc: next address to request.
- inflight_pc: address of the outstanding request.
- Out-entry {if_valid, if_pc, if_instr, if_fault}.
- state ∈ {REQ, WAIT, DRAIN, FAULT}.

Handshakes:
- Request is accepted when imem_req_valid & imem_req_ready.
- Output entry is consumed when if_valid & if_ready; if_valid clears next cycle unless it is reloaded.
- At most one outstanding request.

REQ:
- imem_req_valid = ~if_valid | if_ready (combinational); imem_req_addr = fetch_pc.
- On acceptance: inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32, 0xFFFF_FFFC wraps to 0), next state WAIT.

WAIT:
- No request is issued.
- On imem_resp_valid: load out-entry {1, inflight_pc, data, 0}. If imem_resp_err: load {1, inflight_pc, 0, 2} and go to FAULT; otherwise go to REQ.
- The out-entry is guaranteed empty at response time because requests are only issued when the entry is free.

DRAIN:
- No request is issued.
- On imem_resp_valid: discard the response (err ignored) and go to REQ.

FAULT:
- No requests; hold the fault entry until consumed.
- Stay in FAULT until a redirect arrives.

Redirect (highest priority, any state, same cycle as the pulse):
- Out-entry is cleared (if_valid = 0 next cycle) even if if_ready was high; a consumed-and-flushed entry counts as consumed.
- If redirect_target[1:0] != 0: load {1, redirect_target, 0, 1}. Next state is FAULT, or DRAIN if a request is outstanding.
- Else: fetch_pc <= redirect_target.
- Outstanding request (WAIT with no response this cycle, DRAIN with no response, or REQ accepted this same cycle): next state DRAIN.
- Response arriving in the redirect cycle is discarded; next state REQ.
- A REQ-state request not accepted in the redirect cycle is withdrawn. This is the only permitted drop of an unaccepted valid; imem must tolerate it.
- A DRAIN exit with a pending misaligned-fault entry goes to FAULT, not REQ.

Latency and throughput:
- Request accepted in cycle n, response in n+1, if_valid in n+2.
- Sustained rate is 1 instruction per 2 cycles with zero-wait memory.
- Redirect at cycle r gives the first new request at r+1 (if nothing is outstanding).

Decomposition:
- Package riscfw_pkg:
  - fetch_state_e {REQ, WAIT, DRAIN, FAULT}
  - fetch_fault_e {FAULT_NONE = 0, FAULT_MISALIGN = 1, FAULT_ACCESS = 2}
  - INSN_BYTES = 4
- Sub-module fetch_out_reg: 1-entry valid/ready register with load, flush and consume inputs. It is reusable by later stages.

Test Plan:
- Reset release, imem always ready, 1-cycle response → requests at 0x0, 0x4, 0x8. if_valid first rises 2 cycles after the first accept with if_pc = 0x0. Decode sees 1 entry per 2 cycles.
- if_ready held low for 5 cycles after the entry at 0x4 → no request for 0x8 issued until the cycle if_ready = 1. Entry stays stable.
- Redirect to 0x100 while the request for 0x8 is outstanding → if_valid drops next cycle. The 0x8 response is discarded. Next request addr = 0x100, then if_pc = 0x100.
- Redirect to 0x102 → if_valid with if_pc = 0x102, if_fault = 1, if_instr = 0. No imem requests until a redirect to 0x200 resumes fetch at 0x200.
- Response for 0x10 with imem_resp_err = 1 → entry {0x10, 0, 2}, requests stop. Fetch_pc at 0xFFFF_FFFC → the following request addr = 0x0.
- rst_n asserted mid-WAIT → outputs cleared immediately. After release, the first request = RESET_PC, and the late response from before reset is not seen by decode.

Source files
------------

// File: rtl/riscfw_pkg.sv
// Shared types and constants for the riscfw core front end.
package riscfw_pkg;

  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_ACCESS   = 2'd2
  } fetch_fault_e;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  instr;
    fetch_fault_e fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready pipeline register; load wins over flush and consume.
module fetch_out_reg
  import riscfw_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         flush,
  input  logic         consume,
  input  fetch_entry_t load_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (flush || consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: steers fetch PC, issues imem word reads, and hands
// fetched instructions (or in-band faults) to decode through a 1-entry register.
module fetch_unit
  import riscfw_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [1:0]  if_fault
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic [31:0]  inflight_pc;
  logic         fault_pending;

  logic         req_fire;
  logic         misaligned;
  logic         outstanding;
  logic         out_load;
  logic         out_flush;
  logic         out_consume;
  fetch_entry_t out_load_entry;
  fetch_entry_t out_entry;

  // Gated by rst_n so the request line is low while reset is held.
  always_comb begin
    imem_req_valid = rst_n && (state == REQ) && (!if_valid || if_ready);
    imem_req_addr  = fetch_pc;
  end

  assign req_fire    = imem_req_valid & imem_req_ready;
  assign misaligned  = (redirect_target[1:0] != 2'b00);
  assign out_consume = if_valid & if_ready;

  // A request is still owed a response after this cycle if one was pending
  // and did not return now, or one is being accepted right now.
  always_comb begin
    outstanding = 1'b0;
    if (state == WAIT || state == DRAIN)
      outstanding = !imem_resp_valid;
    else if (state == REQ)
      outstanding = req_fire;
  end

  always_comb begin
    out_load             = 1'b0;
    out_flush            = 1'b0;
    out_load_entry.pc    = inflight_pc;
    out_load_entry.instr = imem_resp_data;
    out_load_entry.fault = FAULT_NONE;
    if (redirect_valid) begin
      out_flush = 1'b1;
      if (misaligned) begin
        out_load             = 1'b1;
        out_load_entry.pc    = redirect_target;
        out_load_entry.instr = '0;
        out_load_entry.fault = FAULT_MISALIGN;
      end
    end else if (state == WAIT && imem_resp_valid) begin
      out_load = 1'b1;
      if (imem_resp_err) begin
        out_load_entry.instr = '0;
        out_load_entry.fault = FAULT_ACCESS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= REQ;
      fetch_pc      <= RESET_PC;
      inflight_pc   <= '0;
      fault_pending <= 1'b0;
    end else if (redirect_valid) begin
      fault_pending <= misaligned;
      if (!misaligned)
        fetch_pc <= redirect_target;
      if (outstanding)
        state <= DRAIN;
      else
        state <= misaligned ? FAULT : REQ;
    end else begin
      unique case (state)
        REQ: begin
          if (req_fire) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'(INSN_BYTES);
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid)
            state <= imem_resp_err ? FAULT : REQ;
        end
        DRAIN: begin
          if (imem_resp_valid)
            state <= fault_pending ? FAULT : REQ;
        end
        FAULT: state <= FAULT;
        default: state <= REQ;
      endcase
    end
  end

  fetch_out_reg u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (out_load),
    .flush      (out_flush),
    .consume    (out_consume),
    .load_entry (out_load_entry),
    .valid      (if_valid),
    .entry      (out_entry)
  );

  assign if_pc    = out_entry.pc;
  assign if_instr = out_entry.instr;
  assign if_fault = out_entry.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; imem answers one cycle after acceptance with ~addr.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  if_fault;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  logic [31:0] last_acc = '0;
  logic        auto_resp;
  logic [31:0] err_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_fault        (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the memory model answers accepted requests next cycle.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req_valid & imem_req_ready;
    a   = imem_req_addr;
    if (acc) begin
      n_acc++;
      last_acc = a;
    end
    @(posedge clk);
    #1;
    if (auto_resp) begin
      imem_resp_valid = acc;
      imem_resp_data  = ~a;
      imem_resp_err   = acc && (a == err_addr);
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid  = 1'b1;
    redirect_target = target;
    tick();
    redirect_valid  = 1'b0;
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    if_ready        = 1'b1;
    auto_resp       = 1'b1;
    err_addr        = 32'h0000_0001;

    #12;
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_fault", {30'd0, if_fault}, 32'd0);

    rst_n = 1'b1;
    #1;
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick();
    chk("lat_if_valid_n1", {31'd0, if_valid}, 32'd0);
    chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("lat_if_valid_n2", {31'd0, if_valid}, 32'd1);
    chk("e0_pc", if_pc, 32'h0);
    chk("e0_instr", if_instr, 32'hFFFF_FFFF);
    chk("e0_fault", {30'd0, if_fault}, 32'd0);
    chk("req4_addr", imem_req_addr, 32'h4);
    tick();
    chk("rate_gap", {31'd0, if_valid}, 32'd0);
    tick();
    chk("e4_pc", if_pc, 32'h4);
    chk("e4_instr", if_instr, 32'hFFFF_FFFB);

    // Backpressure from decode holds the entry and stalls fetch.
    if_ready = 1'b0;
    #1;
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_if_pc", if_pc, 32'h4);
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    chk("stall_acc_count", n_acc, 32'd2);
    if_ready = 1'b1;
    #1;
    chk("unstall_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("unstall_req_addr", imem_req_addr, 32'h8);

    // Redirect in the cycle 0x8 is accepted: its response must be dropped.
    redirect(32'h0000_0100);
    chk("rd_acc_addr", last_acc, 32'h8);
    chk("rd_if_valid", {31'd0, if_valid}, 32'd0);
    chk("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("drain_discard", {31'd0, if_valid}, 32'd0);
    chk("rd_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rd_req_addr", imem_req_addr, 32'h100);
    tick();
    tick();
    chk("e100_pc", if_pc, 32'h100);
    chk("e100_instr", if_instr, 32'hFFFF_FEFF);
    chk("e100_fault", {30'd0, if_fault}, 32'd0);

    // Misaligned redirect while 0x104 is being accepted: DRAIN then FAULT.
    redirect(32'h0000_0102);
    chk("mis_if_valid", {31'd0, if_valid}, 32'd1);
    chk("mis_if_pc", if_pc, 32'h102);
    chk("mis_if_instr", if_instr, 32'h0);
    chk("mis_if_fault", {30'd0, if_fault}, 32'd1);
    chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    if_ready = 1'b0;
    tick();
    chk("mis_hold_pc", if_pc, 32'h102);
    chk("mis_hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    if_ready = 1'b1;
    tick();
    chk("mis_consumed", {31'd0, if_valid}, 32'd0);
    chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("fault_still_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("fault_acc_count", n_acc, 32'd5);
    redirect(32'h0000_0200);
    chk("resume_req_addr", imem_req_addr, 32'h200);
    chk("resume_req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();
    tick();
    chk("e200_pc", if_pc, 32'h200);
    chk("e200_instr", if_instr, 32'hFFFF_FDFF);

    // Unaccepted request withdrawn by redirect, then an access fault at 0x10.
    err_addr       = 32'h0000_0010;
    imem_req_ready = 1'b0;
    redirect(32'h0000_0010);
    chk("wd_if_valid", {31'd0, if_valid}, 32'd0);
    chk("wd_acc_count", n_acc, 32'd6);
    imem_req_ready = 1'b1;
    #1;
    chk("acc10_req_addr", imem_req_addr, 32'h10);
    tick();
    tick();
    chk("af_if_valid", {31'd0, if_valid}, 32'd1);
    chk("af_if_pc", if_pc, 32'h10);
    chk("af_if_instr", if_instr, 32'h0);
    chk("af_if_fault", {30'd0, if_fault}, 32'd2);
    chk("af_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("af_consumed", {31'd0, if_valid}, 32'd0);
    chk("af_still_no_req", {31'd0, imem_req_valid}, 32'd0);

    // Address wrap at the top of the 32-bit space.
    redirect(32'hFFFF_FFFC);
    chk("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_instr", if_instr, 32'h0000_0003);
    chk("wrap_req_addr1", imem_req_addr, 32'h0);

    // Reset while a response is owed; the late response must not reach decode.
    auto_resp = 1'b0;
    tick();
    chk("pre_rst_wait", {31'd0, imem_req_valid}, 32'd0);
    chk("pre_rst_if_pc", if_pc, 32'hFFFF_FFFC);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_if_pc", if_pc, 32'h0);
    chk("async_rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("async_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    #1;
    rst_n           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    chk("late_resp_ignored", {31'd0, if_valid}, 32'd0);
    auto_resp      = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);
    tick();
    tick();
    chk("post_rst_if_pc", if_pc, 32'h0);
    chk("post_rst_if_instr", if_instr, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
